// File: rtl/ext_interrupt_ctrl.sv
// External interrupt controller: rising-edge gateways, enable mask, fixed
// lowest-id-wins arbitration and a claim/complete handshake to one hart.
module ext_interrupt_ctrl #(
   parameter int NSRC = 8
) (
   input  logic            I_clk,
   input  logic            I_rst,
   input  logic [NSRC-1:0] I_irq,
   input  logic [1:0]      I_addr,
   input  logic            I_wen,
   input  logic            I_ren,
   input  logic [31:0]     I_wdata,
   output logic [31:0]     O_rdata,
   output logic            O_extinterrupt,
   output logic [4:0]      O_irqid
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_BUSY   = 2'd2
   } state_e;

   localparam logic [1:0] A_PENDING = 2'd0;
   localparam logic [1:0] A_ENABLE  = 2'd1;
   localparam logic [1:0] A_CLAIM   = 2'd2;
   localparam logic [1:0] A_STATUS  = 2'd3;

   state_e          state_q, state_d;
   logic [NSRC-1:0] irq_q;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] enable_q, enable_d;
   logic [4:0]      claimed_q, claimed_d;
   logic            ext_q;

   logic [NSRC-1:0] edges;
   logic [NSRC-1:0] masked;
   logic [NSRC-1:0] best_oh;
   logic [NSRC-1:0] clr;
   logic [4:0]      best_id;
   logic            claim_rd;
   logic            complete_wr;
   logic            unused_wdata;

   assign edges        = I_irq & ~irq_q;
   assign masked       = pending_q & enable_q;
   assign claim_rd     = I_ren && (I_addr == A_CLAIM);
   // A simultaneous read strobe turns a claim-address write into a pure claim.
   assign complete_wr  = I_wen && !I_ren && (I_addr == A_CLAIM);
   assign unused_wdata = ^I_wdata;

   // Descending scan so the lowest set index is the last assignment made.
   always_comb begin
      best_id = 5'd0;
      best_oh = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (masked[i]) begin
            best_id    = 5'(i + 1);
            best_oh    = '0;
            best_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      claimed_d = claimed_q;
      clr       = '0;
      enable_d  = enable_q;
      case (state_q)
         ST_IDLE: begin
            if (best_id != 5'd0) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (claim_rd && (best_id != 5'd0)) begin
               clr       = best_oh;
               claimed_d = best_id;
               state_d   = ST_BUSY;
            end else if (best_id == 5'd0) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (complete_wr && (I_wdata[4:0] == claimed_q)) begin
               claimed_d = 5'd0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A fresh edge on the bit being claimed keeps it pending.
      pending_d = (pending_q & ~clr) | edges;
      if (I_wen && (I_addr == A_ENABLE)) enable_d = I_wdata[NSRC-1:0];
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q   <= ST_IDLE;
         irq_q     <= '0;
         pending_q <= '0;
         enable_q  <= '0;
         claimed_q <= 5'd0;
         ext_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         irq_q     <= I_irq;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         claimed_q <= claimed_d;
         ext_q     <= (state_d == ST_ASSERT);
      end
   end

   always_comb begin
      O_rdata = 32'd0;
      case (I_addr)
         A_PENDING: O_rdata[NSRC-1:0] = pending_q;
         A_ENABLE:  O_rdata[NSRC-1:0] = enable_q;
         A_CLAIM:   O_rdata[4:0]      = (state_q == ST_BUSY) ? 5'd0 : best_id;
         A_STATUS: begin
            O_rdata[9:8] = state_q;
            O_rdata[4:0] = claimed_q;
         end
         default: O_rdata = 32'd0;
      endcase
   end

   assign O_extinterrupt = ext_q;
   assign O_irqid        = best_id;

endmodule

// File: tb/tb_ext_interrupt_ctrl.sv
// Directed bench for ext_interrupt_ctrl (NSRC=8) with hand-computed expectations.
module tb_ext_interrupt_ctrl;

   logic        I_clk = 1'b0;
   logic        I_rst = 1'b1;
   logic [7:0]  I_irq = '0;
   logic [1:0]  I_addr = '0;
   logic        I_wen = 1'b0;
   logic        I_ren = 1'b0;
   logic [31:0] I_wdata = '0;
   logic [31:0] O_rdata;
   logic        O_extinterrupt;
   logic [4:0]  O_irqid;

   int n_vec = 0;
   int n_err = 0;

   ext_interrupt_ctrl #(.NSRC(8)) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_irq(I_irq), .I_addr(I_addr),
      .I_wen(I_wen), .I_ren(I_ren), .I_wdata(I_wdata), .O_rdata(O_rdata),
      .O_extinterrupt(O_extinterrupt), .O_irqid(O_irqid)
   );

   always #5 I_clk = ~I_clk;

   task automatic cyc();
      @(posedge I_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
      I_addr = addr;
      #1;
      check(tag, O_rdata, exp);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      I_addr  = addr;
      I_wdata = data;
      I_wen   = 1'b1;
      cyc();
      I_wen   = 1'b0;
   endtask

   task automatic claim(input logic [31:0] exp, input string tag);
      I_addr = 2'd2;
      I_ren  = 1'b1;
      #1;
      check(tag, O_rdata, exp);
      cyc();
      I_ren  = 1'b0;
   endtask

   task automatic chk_ext(input logic exp, input string tag);
      check(tag, {31'd0, O_extinterrupt}, {31'd0, exp});
   endtask

   initial begin
      // Reset
      cyc();
      cyc();
      I_rst = 1'b0;
      chk_ext(1'b0, "rst_ext");
      check("rst_irqid", {27'd0, O_irqid}, 32'd0);
      rd(2'd3, 32'h0, "rst_status");
      rd(2'd0, 32'h0, "rst_pending");
      rd(2'd1, 32'h0, "rst_enable");

      // Basic claim/complete, two-edge latency, mismatched complete
      wr(2'd1, 32'h01);
      rd(2'd1, 32'h01, "en_01");
      I_irq = 8'h01;
      cyc();
      I_irq = 8'h00;
      chk_ext(1'b0, "lat_edge1");
      cyc();
      chk_ext(1'b1, "lat_edge2");
      check("irqid_1", {27'd0, O_irqid}, 32'd1);
      rd(2'd3, 32'h100, "status_assert");
      claim(32'd1, "claim_1");
      chk_ext(1'b0, "ext_fall");
      rd(2'd3, 32'h201, "status_busy1");
      rd(2'd0, 32'h0, "pend_after_claim");
      claim(32'd0, "claim_in_busy");
      rd(2'd3, 32'h201, "busy_claim_nochange");
      wr(2'd2, 32'd2);
      rd(2'd3, 32'h201, "bad_complete");
      wr(2'd2, 32'd1);
      rd(2'd3, 32'h0, "good_complete");
      cyc();
      chk_ext(1'b0, "idle_quiet");

      // Masked source, late enable, enable removal drops request
      wr(2'd1, 32'h0);
      I_irq = 8'h08;
      cyc();
      cyc();
      rd(2'd0, 32'h08, "pend_masked");
      chk_ext(1'b0, "masked_ext");
      check("masked_irqid", {27'd0, O_irqid}, 32'd0);
      wr(2'd1, 32'hFFFF_FF08);
      chk_ext(1'b0, "en_late_edge1");
      rd(2'd1, 32'h08, "en_width");
      cyc();
      chk_ext(1'b1, "en_late_edge2");
      check("irqid_4", {27'd0, O_irqid}, 32'd4);
      wr(2'd1, 32'h0);
      chk_ext(1'b1, "dis_edge1");
      cyc();
      chk_ext(1'b0, "dis_edge2");
      rd(2'd3, 32'h0, "dis_status");
      wr(2'd1, 32'h08);
      claim(32'd4, "claim_idle");
      rd(2'd0, 32'h08, "idle_claim_pend");
      rd(2'd3, 32'h100, "idle_claim_status");
      claim(32'd4, "claim_4");
      rd(2'd3, 32'h204, "status_busy4");
      rd(2'd0, 32'h0, "pend_clr4");
      wr(2'd2, 32'd4);
      I_irq = 8'h00;

      // Two simultaneous sources, edge during BUSY, wen+ren on claim
      wr(2'd1, 32'hFF);
      I_irq = 8'h24;
      cyc();
      I_irq = 8'h00;
      cyc();
      check("irqid_3", {27'd0, O_irqid}, 32'd3);
      claim(32'd3, "claim_3");
      rd(2'd0, 32'h20, "pend_20");
      I_irq = 8'h02;
      cyc();
      I_irq = 8'h00;
      rd(2'd0, 32'h22, "pend_busy_edge");
      rd(2'd3, 32'h203, "status_busy3");
      chk_ext(1'b0, "busy_ext");
      wr(2'd2, 32'd3);
      cyc();
      check("irqid_2", {27'd0, O_irqid}, 32'd2);
      claim(32'd2, "claim_2");
      wr(2'd2, 32'd2);
      cyc();
      claim(32'd6, "claim_6");
      I_addr  = 2'd2;
      I_wdata = 32'd6;
      I_wen   = 1'b1;
      I_ren   = 1'b1;
      #1;
      check("wen_ren_rdata", O_rdata, 32'd0);
      cyc();
      I_wen = 1'b0;
      I_ren = 1'b0;
      rd(2'd3, 32'h206, "wen_ren_claim_only");
      wr(2'd2, 32'd6);
      rd(2'd3, 32'h0, "status_idle6");
      rd(2'd0, 32'h0, "pend_empty");

      // Set wins over claim of the same source
      I_irq = 8'h01;
      cyc();
      I_irq = 8'h00;
      cyc();
      I_irq = 8'h01;
      claim(32'd1, "claim_race");
      I_irq = 8'h00;
      rd(2'd0, 32'h01, "pend_set_wins");
      rd(2'd3, 32'h201, "status_race");
      wr(2'd2, 32'd1);
      cyc();
      chk_ext(1'b1, "rearb_ext");
      check("rearb_irqid", {27'd0, O_irqid}, 32'd1);

      // Reset in BUSY overrides a concurrent write; held source seen after release
      claim(32'd1, "claim_pre_rst");
      I_irq   = 8'h80;
      I_rst   = 1'b1;
      I_addr  = 2'd1;
      I_wdata = 32'hFF;
      I_wen   = 1'b1;
      cyc();
      I_rst = 1'b0;
      I_wen = 1'b0;
      rd(2'd3, 32'h0, "rst_busy_status");
      rd(2'd0, 32'h0, "rst_busy_pend");
      rd(2'd1, 32'h0, "rst_busy_en");
      chk_ext(1'b0, "rst_busy_ext");
      cyc();
      rd(2'd0, 32'h80, "held_through_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
